// File: rtl/bomb_engine.sv
// Bomb, blast and health engine for the bomberman arena: one bomb slot per player,
// wall-clipped cross-shaped blasts, chain detonation, damage and a latched game result.
module bomb_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int COORD_W     = 4,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_LEN   = 1,
  parameter int HEALTH_INIT = 3,
  parameter int HEALTH_W    = 2,
  localparam int N_CELLS    = GRID_W * GRID_H,
  localparam int WIN_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [NUM_PLAYERS-1:0]          place_req,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  place_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  place_y,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  player_y,
  input  logic [N_CELLS-1:0]              wall_map,
  output logic [N_CELLS-1:0]              bomb_map,
  output logic [N_CELLS-1:0]              blast_map,
  output logic [NUM_PLAYERS-1:0]          place_ack,
  output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
  output logic                            game_over,
  output logic                            draw,
  output logic [WIN_W-1:0]                winner
);

  localparam int IDX_W  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int FUSE_W = $clog2(FUSE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, ARMED, BLAST} slot_state_t;

  slot_state_t         state_q [NUM_PLAYERS];
  slot_state_t         state_d [NUM_PLAYERS];
  logic [FUSE_W-1:0]   fuse_q  [NUM_PLAYERS];
  logic [FUSE_W-1:0]   fuse_d  [NUM_PLAYERS];
  logic [COORD_W-1:0]  sx_q    [NUM_PLAYERS];
  logic [COORD_W-1:0]  sy_q    [NUM_PLAYERS];
  logic [COORD_W-1:0]  sx_d    [NUM_PLAYERS];
  logic [COORD_W-1:0]  sy_d    [NUM_PLAYERS];
  logic [HEALTH_W-1:0] health_q[NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] ack_d;
  logic [NUM_PLAYERS-1:0] hit;
  logic [N_CELLS-1:0]     taken;
  logic [N_CELLS-1:0]     bomb_d;
  logic [N_CELLS-1:0]     blast_d;
  logic [WIN_W-1:0]       first_alive;
  int                     alive_cnt;

  function automatic logic [IDX_W-1:0] cell_idx(input int x, input int y);
    return IDX_W'(y * GRID_W + x);
  endfunction

  function automatic logic in_grid(input int x, input int y);
    return (x >= 0) && (x < GRID_W) && (y >= 0) && (y < GRID_H);
  endfunction

  // Each arm grows outward and stops at the grid edge or just before the first wall.
  function automatic logic [N_CELLS-1:0] footprint(input int cx, input int cy,
                                                   input logic [N_CELLS-1:0] walls);
    logic [N_CELLS-1:0] fp;
    logic               reach;
    int                 x, y;
    fp = '0;
    fp[cell_idx(cx, cy)] = 1'b1;
    for (int dir = 0; dir < 4; dir++) begin
      reach = 1'b1;
      for (int d = 1; d <= BLAST_LEN; d++) begin
        x = cx;
        y = cy;
        case (dir)
          0:       x = cx + d;
          1:       x = cx - d;
          2:       y = cy + d;
          default: y = cy - d;
        endcase
        if (!in_grid(x, y))               reach = 1'b0;
        else if (walls[cell_idx(x, y)])   reach = 1'b0;
        if (reach) fp[cell_idx(x, y)] = 1'b1;
      end
    end
    return fp;
  endfunction

  always_comb begin : slot_next
    int               rx, ry;
    logic [IDX_W-1:0] ri;
    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    taken   = '0;
    ack_d   = '0;
    bomb_d  = '0;
    blast_d = '0;
    ri      = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      state_d[p] = state_q[p];
      fuse_d[p]  = fuse_q[p];
      sx_d[p]    = sx_q[p];
      sy_d[p]    = sy_q[p];
      rx = int'(place_x[p*COORD_W +: COORD_W]);
      ry = int'(place_y[p*COORD_W +: COORD_W]);
      case (state_q[p])
        IDLE: begin
          // Ascending player order lets the lowest index claim a contested cell first.
          if (place_req[p] && !game_over && in_grid(rx, ry)) begin
            ri = cell_idx(rx, ry);
            if (!wall_map[ri] && !bomb_map[ri] && !taken[ri]) begin
              state_d[p] = ARMED;
              fuse_d[p]  = FUSE_W'(FUSE_TICKS);
              sx_d[p]    = place_x[p*COORD_W +: COORD_W];
              sy_d[p]    = place_y[p*COORD_W +: COORD_W];
              ack_d[p]   = 1'b1;
              taken[ri]  = 1'b1;
            end
          end
        end
        ARMED: begin
          if (blast_map[cell_idx(int'(sx_q[p]), int'(sy_q[p]))]) begin
            state_d[p] = BLAST;
            fuse_d[p]  = '0;
          end else if (tick) begin
            if (fuse_q[p] == FUSE_W'(1)) begin
              state_d[p] = BLAST;
              fuse_d[p]  = '0;
            end else begin
              fuse_d[p] = fuse_q[p] - FUSE_W'(1);
            end
          end
        end
        BLAST: if (tick) state_d[p] = IDLE;
        default: state_d[p] = IDLE;
      endcase
    end
    // Maps are built from the next slot state so they line up with the slot registers.
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (state_d[p] == ARMED)
        bomb_d[cell_idx(int'(sx_d[p]), int'(sy_d[p]))] = 1'b1;
      if (state_d[p] == BLAST)
        blast_d = blast_d | footprint(int'(sx_d[p]), int'(sy_d[p]), wall_map);
    end
  end

  always_comb begin : player_status
    int px, py;
    hit         = '0;
    alive_cnt   = 0;
    first_alive = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      px = int'(player_x[p*COORD_W +: COORD_W]);
      py = int'(player_y[p*COORD_W +: COORD_W]);
      if (in_grid(px, py)) hit[p] = blast_map[cell_idx(px, py)];
      if (health_q[p] != '0) alive_cnt = alive_cnt + 1;
    end
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (health_q[p] != '0) first_alive = WIN_W'(p);
    end
  end

  // NOTE: state registers use non-blocking assignments only; the slot arrays are
  // small per-player registers, not a memory, so all of them are cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p]  <= IDLE;
        fuse_q[p]   <= '0;
        sx_q[p]     <= '0;
        sy_q[p]     <= '0;
        health_q[p] <= HEALTH_W'(HEALTH_INIT);
      end
      bomb_map  <= '0;
      blast_map <= '0;
      place_ack <= '0;
      game_over <= 1'b0;
      draw      <= 1'b0;
      winner    <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p] <= state_d[p];
        fuse_q[p]  <= fuse_d[p];
        sx_q[p]    <= sx_d[p];
        sy_q[p]    <= sy_d[p];
        if (tick && !game_over && hit[p] && (health_q[p] != '0))
          health_q[p] <= health_q[p] - HEALTH_W'(1);
      end
      bomb_map  <= bomb_d;
      blast_map <= blast_d;
      place_ack <= ack_d;
      if (!game_over && (alive_cnt <= 1)) begin
        game_over <= 1'b1;
        draw      <= (alive_cnt == 0);
        winner    <= first_alive;
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_health
    assign health[p*HEALTH_W +: HEALTH_W] = health_q[p];
  end

endmodule

// File: tb/tb_bomb_engine.sv
// Self-checking bench for bomb_engine: directed scenarios with literal expectations,
// then randomized play compared every cycle against a behavioural arena model.
module tb_bomb_engine;

  localparam int NP = 2;
  localparam int GW = 10;
  localparam int GH = 10;
  localparam int CW = 4;
  localparam int NC = GW * GH;
  localparam int FUSE = 3;
  localparam int BL = 1;
  localparam int HI = 3;
  localparam int HW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tick = 1'b0;
  logic [NP-1:0]    place_req = '0;
  logic [NP*CW-1:0] place_x = '0;
  logic [NP*CW-1:0] place_y = '0;
  logic [NP*CW-1:0] player_x = '0;
  logic [NP*CW-1:0] player_y = '0;
  logic [NC-1:0]    wall_map = '0;
  logic [NC-1:0]    bomb_map;
  logic [NC-1:0]    blast_map;
  logic [NP-1:0]    place_ack;
  logic [NP*HW-1:0] health;
  logic             game_over;
  logic             draw;
  logic [0:0]       winner;

  bomb_engine #(
    .NUM_PLAYERS(NP), .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .FUSE_TICKS(FUSE),
    .BLAST_LEN(BL), .HEALTH_INIT(HI), .HEALTH_W(HW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .place_req(place_req), .place_x(place_x), .place_y(place_y),
    .player_x(player_x), .player_y(player_y), .wall_map(wall_map),
    .bomb_map(bomb_map), .blast_map(blast_map), .place_ack(place_ack),
    .health(health), .game_over(game_over), .draw(draw), .winner(winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural arena: per-player bomb records plus derived cell sets.
  int        m_phase [NP];   // 0 none, 1 armed, 2 blasting
  int        m_fuse  [NP];
  int        m_bx    [NP];
  int        m_by    [NP];
  int        m_health[NP];
  bit [NC-1:0] m_bomb = '0;
  bit [NC-1:0] m_blast = '0;
  bit [NP-1:0] m_ack = '0;
  bit        m_over = 1'b0;
  bit        m_draw = 1'b0;
  int        m_winner = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [127:0] dut_v,
                     input logic [127:0] mod_v, input logic [127:0] exp);
    check(name, dut_v, exp);
    check({name, "_model"}, mod_v, exp);
  endtask

  function automatic bit [NC-1:0] blast_cells(input int cx, input int cy, input bit [NC-1:0] walls);
    int dxs[4] = '{1, -1, 0, 0};
    int dys[4] = '{0, 0, 1, -1};
    bit [NC-1:0] r = '0;
    int nx, ny;
    r[cy*GW + cx] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= BL; k++) begin
        nx = cx + dxs[d] * k;
        ny = cy + dys[d] * k;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) break;
        if (walls[ny*GW + nx]) break;
        r[ny*GW + nx] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] mask5(input int a, input int b, input int c, input int d, input int e);
    logic [NC-1:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    if (e >= 0) m[e] = 1'b1;
    return m;
  endfunction

  function automatic logic [NP*HW-1:0] model_health();
    logic [NP*HW-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p*HW +: HW] = HW'(m_health[p]);
    return v;
  endfunction

  task automatic model_step();
    bit [NC-1:0] old_blast, taken;
    bit          old_over;
    int          old_h[NP];
    int          x, y, alive, survivor;
    old_blast = m_blast;
    old_over  = m_over;
    old_h     = m_health;
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        m_phase[p] = 0; m_fuse[p] = 0; m_bx[p] = 0; m_by[p] = 0; m_health[p] = HI;
      end
      m_bomb = '0; m_blast = '0; m_ack = '0;
      m_over = 1'b0; m_draw = 1'b0; m_winner = 0;
      return;
    end
    taken = '0;
    m_ack = '0;
    for (int p = 0; p < NP; p++) begin
      x = int'(place_x[p*CW +: CW]);
      y = int'(place_y[p*CW +: CW]);
      if (m_phase[p] == 0) begin
        if (place_req[p] && !old_over && x < GW && y < GH) begin
          if (!wall_map[y*GW + x] && !m_bomb[y*GW + x] && !taken[y*GW + x]) begin
            m_phase[p] = 1; m_fuse[p] = FUSE; m_bx[p] = x; m_by[p] = y;
            m_ack[p] = 1'b1; taken[y*GW + x] = 1'b1;
          end
        end
      end else if (m_phase[p] == 1) begin
        if (old_blast[m_by[p]*GW + m_bx[p]]) begin
          m_phase[p] = 2; m_fuse[p] = 0;
        end else if (tick) begin
          m_fuse[p]--;
          if (m_fuse[p] == 0) m_phase[p] = 2;
        end
      end else if (tick) begin
        m_phase[p] = 0;
      end
    end
    m_bomb = '0;
    m_blast = '0;
    for (int p = 0; p < NP; p++) begin
      if (m_phase[p] == 1) m_bomb[m_by[p]*GW + m_bx[p]] = 1'b1;
      if (m_phase[p] == 2) m_blast |= blast_cells(m_bx[p], m_by[p], wall_map);
    end
    if (tick && !old_over) begin
      for (int p = 0; p < NP; p++) begin
        x = int'(player_x[p*CW +: CW]);
        y = int'(player_y[p*CW +: CW]);
        if (x < GW && y < GH && old_blast[y*GW + x] && m_health[p] > 0) m_health[p]--;
      end
    end
    if (!old_over) begin
      alive = 0;
      survivor = 0;
      for (int p = NP - 1; p >= 0; p--) begin
        if (old_h[p] > 0) begin alive++; survivor = p; end
      end
      if (alive <= 1) begin
        m_over = 1'b1;
        m_draw = (alive == 0);
        m_winner = (alive == 1) ? survivor : 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Single compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    check("bomb_map", 128'(bomb_map), 128'(m_bomb));
    check("blast_map", 128'(blast_map), 128'(m_blast));
    check("place_ack", 128'(place_ack), 128'(m_ack));
    for (int p = 0; p < NP; p++)
      check($sformatf("health%0d", p), 128'(health[p*HW +: HW]), 128'(m_health[p]));
    check("game_over", 128'(game_over), 128'(m_over));
    check("draw", 128'(draw), 128'(m_draw));
    if (!m_over || !m_draw) check("winner", 128'(winner), 128'(m_winner));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_tick(input int n = 1);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic place(input int p, input int x, input int y);
    place_req = '0;
    place_req[p] = 1'b1;
    place_x[p*CW +: CW] = CW'(x);
    place_y[p*CW +: CW] = CW'(y);
    step();
    place_req = '0;
  endtask

  task automatic set_player(input int p, input int x, input int y);
    player_x[p*CW +: CW] = CW'(x);
    player_y[p*CW +: CW] = CW'(y);
  endtask

  task automatic reset_game();
    rst = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      m_phase[p] = 0; m_fuse[p] = 0; m_bx[p] = 0; m_by[p] = 0; m_health[p] = HI;
    end
    set_player(0, 9, 9);
    set_player(1, 9, 0);

    // Reset with tick pulsing
    reset_game();
    pin("rst_health", 128'(health), 128'(model_health()), 128'(4'hF));
    pin("rst_bomb", 128'(bomb_map), 128'(m_bomb), 128'(0));
    pin("rst_blast", 128'(blast_map), 128'(m_blast), 128'(0));
    pin("rst_over", 128'(game_over), 128'(m_over), 128'(0));

    // Place and detonate at (2,3)
    place(0, 2, 3);
    pin("ack_pulse", 128'(place_ack), 128'(m_ack), 128'(2'b01));
    pin("bomb32", 128'(bomb_map), 128'(m_bomb), 128'(mask5(32, -1, -1, -1, -1)));
    step();
    pin("ack_drop", 128'(place_ack), 128'(m_ack), 128'(0));
    do_tick(2);
    pin("bomb_before_det", 128'(bomb_map[32]), 128'(m_bomb[32]), 128'(1));
    do_tick();
    pin("blast_cross", 128'(blast_map), 128'(m_blast), 128'(mask5(22, 31, 32, 33, 42)));
    pin("bomb_cleared", 128'(bomb_map[32]), 128'(m_bomb[32]), 128'(0));
    do_tick();
    pin("blast_end", 128'(blast_map), 128'(m_blast), 128'(0));

    // Wall clipping, edge clipping, rejected requests
    wall_map[33] = 1'b1;
    place(0, 2, 3);
    do_tick(3);
    pin("blast_wall", 128'(blast_map), 128'(m_blast), 128'(mask5(22, 31, 32, 42, -1)));
    do_tick();
    place(0, 3, 3);
    pin("ack_wall", 128'(place_ack), 128'(m_ack), 128'(0));
    place(0, 11, 2);
    pin("ack_range", 128'(place_ack), 128'(m_ack), 128'(0));
    wall_map = '0;
    place(1, 0, 0);
    pin("ack_p1", 128'(place_ack), 128'(m_ack), 128'(2'b10));
    do_tick(3);
    pin("blast_corner", 128'(blast_map), 128'(m_blast), 128'(mask5(0, 1, 10, -1, -1)));
    do_tick();

    // Same-cell conflict then chain reaction
    place_req = 2'b11;
    place_x = {4'd5, 4'd5};
    place_y = {4'd5, 4'd5};
    step();
    place_req = '0;
    pin("conflict_ack", 128'(place_ack), 128'(m_ack), 128'(2'b01));
    do_tick(2);
    place(1, 5, 6);
    pin("chain_place", 128'(place_ack), 128'(m_ack), 128'(2'b10));
    do_tick();
    pin("chain_first", 128'(blast_map), 128'(m_blast), 128'(mask5(45, 54, 55, 56, 65)));
    pin("chain_armed", 128'(bomb_map), 128'(m_bomb), 128'(mask5(65, -1, -1, -1, -1)));
    step();
    pin("chain_second", 128'(blast_map), 128'(m_blast),
        128'(mask5(45, 54, 55, 56, 65) | mask5(64, 66, 75, -1, -1)));
    pin("chain_bomb", 128'(bomb_map), 128'(m_bomb), 128'(0));
    do_tick();

    // Overlapping blasts: single decrement
    set_player(1, 2, 4);
    place_req = 2'b11;
    place_x = {4'd2, 4'd2};
    place_y = {4'd5, 4'd3};
    step();
    place_req = '0;
    pin("dual_ack", 128'(place_ack), 128'(m_ack), 128'(2'b11));
    do_tick(3);
    pin("no_dmg_on_det", 128'(health), 128'(model_health()), 128'(4'hF));
    do_tick();
    pin("single_dmg", 128'(health), 128'(model_health()), 128'(4'b1011));

    // Winner run
    place(0, 2, 3);
    do_tick(4);
    step();
    pin("p1_at_1", 128'(health), 128'(model_health()), 128'(4'b0111));
    pin("not_over", 128'(game_over), 128'(m_over), 128'(0));
    place(0, 2, 3);
    do_tick();
    place(1, 7, 7);
    do_tick(3);
    pin("p1_dead", 128'(health), 128'(model_health()), 128'(4'b0011));
    pin("over_lag", 128'(game_over), 128'(m_over), 128'(0));
    step();
    pin("over_win", 128'(game_over), 128'(m_over), 128'(1));
    pin("winner0", 128'(winner), 128'(m_winner), 128'(0));
    pin("no_draw", 128'(draw), 128'(m_draw), 128'(0));
    place(0, 1, 1);
    pin("ack_after_over", 128'(place_ack), 128'(m_ack), 128'(0));
    set_player(0, 7, 7);
    pin("late_blast", 128'(blast_map[77]), 128'(m_blast[77]), 128'(1));
    do_tick();
    pin("no_dmg_after_over", 128'(health), 128'(model_health()), 128'(4'b0011));

    // Draw run
    reset_game();
    set_player(0, 2, 4);
    set_player(1, 2, 4);
    place(0, 2, 3);
    do_tick(4);
    pin("both_2", 128'(health), 128'(model_health()), 128'(4'b1010));
    place(0, 2, 3);
    do_tick(4);
    pin("both_1", 128'(health), 128'(model_health()), 128'(4'b0101));
    place(0, 2, 3);
    do_tick();
    place(1, 7, 7);
    do_tick(3);
    step();
    pin("draw_over", 128'(game_over), 128'(m_over), 128'(1));
    pin("draw_flag", 128'(draw), 128'(m_draw), 128'(1));
    set_player(0, 7, 7);
    set_player(1, 7, 7);
    do_tick();
    pin("draw_health", 128'(health), 128'(model_health()), 128'(0));

    // Randomized play against the model
    for (int ep = 0; ep < 6; ep++) begin
      reset_game();
      for (int c = 0; c < NC; c++) wall_map[c] = ($urandom_range(0, 11) == 0);
      for (int p = 0; p < NP; p++) set_player(p, $urandom_range(0, 9), $urandom_range(0, 9));
      for (int cyc = 0; cyc < 500; cyc++) begin
        rst  = ($urandom_range(0, 399) != 0);
        tick = ($urandom_range(0, 3) == 0);
        for (int p = 0; p < NP; p++) begin
          place_req[p] = ($urandom_range(0, 3) == 0);
          place_x[p*CW +: CW] = CW'($urandom_range(0, 11));
          place_y[p*CW +: CW] = CW'($urandom_range(0, 11));
          if ($urandom_range(0, 7) == 0)
            set_player(p, $urandom_range(0, 10), $urandom_range(0, 9));
        end
        if ($urandom_range(0, 2) == 0) begin
          place_x[CW +: CW] = place_x[0 +: CW];
          place_y[CW +: CW] = place_y[0 +: CW];
        end
        if ($urandom_range(0, 49) == 0) begin
          int wc;
          wc = $urandom_range(0, NC - 1);
          wall_map[wc] = ~wall_map[wc];
        end
        step();
      end
      tick = 1'b0;
      place_req = '0;
      rst = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_engine.md
# bomb_engine

Parametrised bomb/blast/health engine for the bomberman arena. It generalises the fixed two-player, 10x10, separately-clocked bomb logic to N players and a configurable grid, fuse length and blast length. Added behaviour: walls stop blasts, bombs chain-detonate, and an explicit winner/draw result is produced. It runs on the system clock with a 1 Hz `tick` strobe, takes player positions and bomb requests from character control, and drives the VGA and seven-segment paths.

## Interface
- `NUM_PLAYERS`, 2: player count; each player owns one bomb slot.
- `GRID_W`, 10: arena width in cells.
- `GRID_H`, 10: arena height in cells.
- `COORD_W`, 4: width of each x/y coordinate.
- `FUSE_TICKS`, 3: ticks from placement to detonation; must be at least 1.
- `BLAST_LEN`, 1: blast reach in cells in each of the four directions.
- `HEALTH_INIT`, 3: starting health per player.
- `HEALTH_W`, 2: width of each player's health field.
- `clk  in  1`: system clock.
- `rst  in  1`: reset; synchronous, active-low.
- `tick  in  1`: one-cycle enable strobe, nominally 1 Hz.
- `place_req  in  NUM_PLAYERS`: bit p requests a bomb from player p.
- `place_x`, `place_y`  in  NUM_PLAYERS*COORD_W: requested bomb cell, player p in bits [p*COORD_W +: COORD_W].
- `player_x`, `player_y`  in  NUM_PLAYERS*COORD_W: current player positions, same packing.
- `wall_map  in  GRID_W*GRID_H`: 1 = wall; cell index = y*GRID_W + x.
- `bomb_map  out  GRID_W*GRID_H`: 1 = armed bomb in that cell.
- `blast_map  out  GRID_W*GRID_H`: 1 = cell currently in a blast.
- `place_ack  out  NUM_PLAYERS`: one-cycle acceptance pulse per player.
- `health  out  NUM_PLAYERS*HEALTH_W`: health per player, packed like the coordinates.
- `game_over  out  1`: latched end-of-game flag.
- `draw  out  1`: valid while `game_over`=1; no survivors.
- `winner  out  max(1,$clog2(NUM_PLAYERS))`: index of the surviving player; valid while `game_over`=1 and `draw`=0.

## Operation
- Each slot is a state machine with states IDLE, ARMED and BLAST, plus a fuse counter and a latched cell coordinate.
- IDLE → ARMED on `place_req[p]` when all of the following hold:
  - the game is not over;
  - the coordinate is in range (x<GRID_W, y<GRID_H);
  - the cell is not a wall;
  - no ARMED slot occupies the cell.
  - On acceptance: fuse loads `FUSE_TICKS` and `place_ack[p]` pulses.
- A request is ignored (no ack) if it fails any condition above or if its slot is not IDLE.
- Same-cycle requests for the same cell: the lowest player index wins; the others get no ack.
- ARMED: fuse decrements on each `tick`. On the `tick` where fuse==1, the slot goes to BLAST.
- Chain reaction: an ARMED slot whose cell has `blast_map`=1 goes to BLAST on the next cycle, regardless of `tick`. Each chain hop adds one cycle.
- BLAST → IDLE on the next `tick`.
- Blast footprint:
  - the centre cell;
  - up to `BLAST_LEN` cells in each of the four directions;
  - each arm is clipped at the grid edge and stops before the first wall cell (the wall cell is excluded).
- `bomb_map` is the OR of ARMED slot cells. `blast_map` is the OR of BLAST slot footprints. Both are registered from the slot state.
- Damage is evaluated on each `tick`:
  - player p loses 1 health if their cell has `blast_map`=1 on that cycle;
  - at most 1 per tick regardless of overlapping blasts;
  - saturates at 0.
- No damage is applied once `game_over`=1.
- End of game: when at most one player has health>0, `game_over` latches to 1.
  - `winner` = index of the survivor.
  - `draw` = 1 if no player has health>0.
  - The flag holds until reset.
- Slots keep expiring normally after `game_over`.

## Timing
- Reset (rst=0 at a clk edge), next cycle:
  - all slots IDLE; fuse counters 0;
  - `bomb_map`=0, `blast_map`=0, `place_ack`=0;
  - each health field = `HEALTH_INIT`;
  - `game_over`=0, `draw`=0, `winner`=0.
- Reset mid-blast or mid-fuse discards all state; `tick` is ignored during reset.
- `place_req` at cycle n → `place_ack` and the `bomb_map` bit at n+1.
- Detonating `tick` at t → `blast_map` set and `bomb_map` bit cleared at t+1.
- Chained slot → its `blast_map` appears one cycle after the triggering `blast_map`.
- Damage `tick` at t → `health` updated at t+1 → `game_over`/`winner`/`draw` at t+2.
- A `tick` coinciding with `place_req` in the same cycle: placement wins and the fuse is not decremented that cycle.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with `tick` pulsing → `health`={3,3}, all maps 0, `game_over`=0.
- **Place and detonate:** P0 requests (2,3), no walls → `place_ack[0]`=1 for one cycle and `bomb_map[32]`=1. After the 3rd `tick`, `blast_map` bits {22,31,32,33,42}=1 and `bomb_map[32]`=0. The next `tick` clears `blast_map`.
- **Clipping:**
  - wall at 33 with a bomb at (2,3) → bit 33 stays 0;
  - bomb at (0,0) → `blast_map` bits are exactly {0,1,10};
  - request at (11,2) or onto a wall → no ack.
- **Conflict and chain:**
  - P0 and P1 both request (5,5) in the same cycle → only `place_ack[0]` pulses.
  - P1 then places at (5,6) with 2 ticks left on its fuse when P0's bomb detonates → P1's bits {55,64,65,66,75} are set one cycle after P0's `blast_map`.
- **Damage:** P1 at (2,4) under two overlapping blasts at the ending `tick` → `health[1]` goes 3→2, a single decrement.
- **End of game:**
  - P1 at health 1 is hit → next cycle `game_over`=1, `winner`=0, `draw`=0.
  - Separate run: both players at health 1 hit on the same `tick` → `game_over`=1, `draw`=1.
  - In both runs, later blasts leave health unchanged.
